// File: rtl/decode_stage.sv
// Instruction-decode stage: register file, control/immediate decode, hazard stalls,
// branch resolution and the ID/EX pipeline register feeding execute.
module decode_stage (
    input  logic        clk,
    input  logic        rst,
    input  logic        ifid_valid,
    input  logic [15:0] ifid_instr,
    input  logic [15:0] ifid_pc2,
    input  logic        wb_we,
    input  logic [3:0]  wb_rd,
    input  logic [15:0] wb_data,
    input  logic [2:0]  ex_flags,
    input  logic        exmem_valid,
    input  logic        exmem_reg_write,
    input  logic [3:0]  exmem_rd,
    output logic        stall,
    output logic        branch_taken,
    output logic [15:0] branch_target,
    output logic        halted,
    output logic        idex_valid,
    output logic [3:0]  idex_opcode,
    output logic [15:0] idex_pc2,
    output logic [15:0] idex_rs_data,
    output logic [15:0] idex_rt_data,
    output logic [15:0] idex_imm,
    output logic [3:0]  idex_rs,
    output logic [3:0]  idex_rt,
    output logic [3:0]  idex_rd,
    output logic        idex_alu_src,
    output logic        idex_reg_write,
    output logic        idex_mem_read,
    output logic        idex_mem_write,
    output logic        idex_halt,
    output logic [2:0]  idex_flag_en
);
    localparam logic [3:0] OP_ADD = 4'h0, OP_SUB = 4'h1, OP_XOR = 4'h2, OP_RED = 4'h3,
                           OP_SLL = 4'h4, OP_SRA = 4'h5, OP_ROR = 4'h6, OP_PADDSB = 4'h7,
                           OP_LW  = 4'h8, OP_SW  = 4'h9, OP_LHB = 4'hA, OP_LLB = 4'hB,
                           OP_B   = 4'hC, OP_BR  = 4'hD, OP_PCS = 4'hE, OP_HLT = 4'hF;

    logic [15:0] rf_q [16];
    logic        halted_q;

    logic        idex_valid_q, idex_alu_src_q, idex_reg_write_q, idex_mem_read_q;
    logic        idex_mem_write_q, idex_halt_q;
    logic [3:0]  idex_opcode_q, idex_rs_q, idex_rt_q, idex_rd_q;
    logic [15:0] idex_pc2_q, idex_rs_data_q, idex_rt_data_q, idex_imm_q;
    logic [2:0]  idex_flag_en_q;

    logic [3:0]  opcode, src1, src2, rs_num, rt_num;
    logic        uses_src1, uses_src2, reg_write, alu_src, mem_read, mem_write;
    logic        is_b, is_br, is_hlt, cond_true;
    logic [15:0] imm, rs_val, rt_val;
    logic [2:0]  flag_en, ccc;
    logic        active, load_use, flag_haz, br_haz, load;

    always_comb begin
        opcode    = ifid_instr[15:12];
        src1      = ifid_instr[7:4];
        src2      = ifid_instr[3:0];
        uses_src1 = 1'b0;
        uses_src2 = 1'b0;
        reg_write = 1'b0;
        alu_src   = 1'b0;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        is_b      = 1'b0;
        is_br     = 1'b0;
        is_hlt    = 1'b0;
        imm       = 16'h0000;
        flag_en   = 3'b000;
        case (opcode)
            OP_ADD, OP_SUB: begin
                uses_src1 = 1'b1; uses_src2 = 1'b1; reg_write = 1'b1; flag_en = 3'b111;
            end
            OP_XOR: begin
                uses_src1 = 1'b1; uses_src2 = 1'b1; reg_write = 1'b1; flag_en = 3'b010;
            end
            OP_RED, OP_PADDSB: begin
                uses_src1 = 1'b1; uses_src2 = 1'b1; reg_write = 1'b1;
            end
            OP_SLL, OP_SRA, OP_ROR: begin
                uses_src1 = 1'b1; reg_write = 1'b1; alu_src = 1'b1; flag_en = 3'b010;
                imm = {12'h000, ifid_instr[3:0]};
            end
            OP_LW: begin
                uses_src1 = 1'b1; reg_write = 1'b1; alu_src = 1'b1; mem_read = 1'b1;
                imm = {{11{ifid_instr[3]}}, ifid_instr[3:0], 1'b0};
            end
            OP_SW: begin
                uses_src1 = 1'b1; uses_src2 = 1'b1; alu_src = 1'b1; mem_write = 1'b1;
                src2 = ifid_instr[11:8];
                imm = {{11{ifid_instr[3]}}, ifid_instr[3:0], 1'b0};
            end
            OP_LHB, OP_LLB: begin
                uses_src1 = 1'b1; reg_write = 1'b1; alu_src = 1'b1;
                src1 = ifid_instr[11:8];
                imm = {8'h00, ifid_instr[7:0]};
            end
            OP_B:    is_b = 1'b1;
            OP_BR:   begin is_br = 1'b1; uses_src1 = 1'b1; end
            OP_PCS:  reg_write = 1'b1;
            OP_HLT:  is_hlt = 1'b1;
            default: ;
        endcase
        // Unused source slots read as R0 so they never trip hazards or forwarding.
        rs_num = uses_src1 ? src1 : 4'd0;
        rt_num = uses_src2 ? src2 : 4'd0;
    end

    always_comb begin
        rs_val = rf_q[rs_num];
        if (rs_num == 4'd0)                 rs_val = 16'h0000;
        else if (wb_we && wb_rd == rs_num)  rs_val = wb_data;
        rt_val = rf_q[rt_num];
        if (rt_num == 4'd0)                 rt_val = 16'h0000;
        else if (wb_we && wb_rd == rt_num)  rt_val = wb_data;
    end

    // ex_flags = {N,Z,V}
    always_comb begin
        ccc = ifid_instr[11:9];
        case (ccc)
            3'b000:  cond_true = ~ex_flags[1];
            3'b001:  cond_true = ex_flags[1];
            3'b010:  cond_true = ~ex_flags[1] & ~ex_flags[2];
            3'b011:  cond_true = ex_flags[2];
            3'b100:  cond_true = ex_flags[1] | ~ex_flags[2];
            3'b101:  cond_true = ex_flags[2] | ex_flags[1];
            3'b110:  cond_true = ex_flags[0];
            default: cond_true = 1'b1;
        endcase
    end

    assign active   = ifid_valid & ~halted_q;
    assign load_use = idex_valid_q & idex_mem_read_q & (idex_rd_q != 4'd0) &
                      ((idex_rd_q == rs_num) | (idex_rd_q == rt_num));
    assign flag_haz = (is_b | is_br) & (ccc != 3'b111) & idex_valid_q & (|idex_flag_en_q);
    assign br_haz   = is_br & (rs_num != 4'd0) &
                      ((idex_valid_q & idex_reg_write_q & (idex_rd_q == rs_num)) |
                       (exmem_valid & exmem_reg_write & (exmem_rd == rs_num)));

    assign stall         = halted_q | (active & (load_use | flag_haz | br_haz));
    assign branch_taken  = active & ~stall & (is_b | is_br) & cond_true;
    assign branch_target = is_br ? rs_val
                                 : ifid_pc2 + {{6{ifid_instr[8]}}, ifid_instr[8:0], 1'b0};
    assign load          = active & ~stall & ~is_b & ~is_br;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 16; i++) rf_q[i] <= 16'h0000;
        end else if (wb_we && wb_rd != 4'd0) begin
            rf_q[wb_rd] <= wb_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            halted_q         <= 1'b0;
            idex_valid_q     <= 1'b0;
            idex_opcode_q    <= 4'd0;
            idex_pc2_q       <= 16'h0000;
            idex_rs_data_q   <= 16'h0000;
            idex_rt_data_q   <= 16'h0000;
            idex_imm_q       <= 16'h0000;
            idex_rs_q        <= 4'd0;
            idex_rt_q        <= 4'd0;
            idex_rd_q        <= 4'd0;
            idex_alu_src_q   <= 1'b0;
            idex_reg_write_q <= 1'b0;
            idex_mem_read_q  <= 1'b0;
            idex_mem_write_q <= 1'b0;
            idex_halt_q      <= 1'b0;
            idex_flag_en_q   <= 3'b000;
        end else begin
            halted_q         <= halted_q | (load & is_hlt);
            idex_valid_q     <= load;
            idex_opcode_q    <= opcode;
            idex_pc2_q       <= ifid_pc2;
            idex_rs_data_q   <= rs_val;
            idex_rt_data_q   <= rt_val;
            idex_imm_q       <= imm;
            idex_rs_q        <= rs_num;
            idex_rt_q        <= rt_num;
            idex_rd_q        <= ifid_instr[11:8];
            idex_alu_src_q   <= load & alu_src;
            idex_reg_write_q <= load & reg_write;
            idex_mem_read_q  <= load & mem_read;
            idex_mem_write_q <= load & mem_write;
            idex_halt_q      <= load & is_hlt;
            idex_flag_en_q   <= load ? flag_en : 3'b000;
        end
    end

    assign halted         = halted_q;
    assign idex_valid     = idex_valid_q;
    assign idex_opcode    = idex_opcode_q;
    assign idex_pc2       = idex_pc2_q;
    assign idex_rs_data   = idex_rs_data_q;
    assign idex_rt_data   = idex_rt_data_q;
    assign idex_imm       = idex_imm_q;
    assign idex_rs        = idex_rs_q;
    assign idex_rt        = idex_rt_q;
    assign idex_rd        = idex_rd_q;
    assign idex_alu_src   = idex_alu_src_q;
    assign idex_reg_write = idex_reg_write_q;
    assign idex_mem_read  = idex_mem_read_q;
    assign idex_mem_write = idex_mem_write_q;
    assign idex_halt      = idex_halt_q;
    assign idex_flag_en   = idex_flag_en_q;
endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage: a vector table for single-instruction decode plus
// hand-written sequences for the multi-cycle hazard, branch, halt and reset cases.
module tb_decode_stage;
    logic        clk = 1'b0;
    logic        rst;
    logic        ifid_valid;
    logic [15:0] ifid_instr, ifid_pc2;
    logic        wb_we;
    logic [3:0]  wb_rd;
    logic [15:0] wb_data;
    logic [2:0]  ex_flags;
    logic        exmem_valid, exmem_reg_write;
    logic [3:0]  exmem_rd;
    logic        stall, branch_taken, halted, idex_valid;
    logic [15:0] branch_target, idex_pc2, idex_rs_data, idex_rt_data, idex_imm;
    logic [3:0]  idex_opcode, idex_rs, idex_rt, idex_rd;
    logic        idex_alu_src, idex_reg_write, idex_mem_read, idex_mem_write, idex_halt;
    logic [2:0]  idex_flag_en;

    int n_chk = 0;
    int n_fail = 0;

    decode_stage dut (
        .clk(clk), .rst(rst),
        .ifid_valid(ifid_valid), .ifid_instr(ifid_instr), .ifid_pc2(ifid_pc2),
        .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data), .ex_flags(ex_flags),
        .exmem_valid(exmem_valid), .exmem_reg_write(exmem_reg_write), .exmem_rd(exmem_rd),
        .stall(stall), .branch_taken(branch_taken), .branch_target(branch_target),
        .halted(halted), .idex_valid(idex_valid), .idex_opcode(idex_opcode),
        .idex_pc2(idex_pc2), .idex_rs_data(idex_rs_data), .idex_rt_data(idex_rt_data),
        .idex_imm(idex_imm), .idex_rs(idex_rs), .idex_rt(idex_rt), .idex_rd(idex_rd),
        .idex_alu_src(idex_alu_src), .idex_reg_write(idex_reg_write),
        .idex_mem_read(idex_mem_read), .idex_mem_write(idex_mem_write),
        .idex_halt(idex_halt), .idex_flag_en(idex_flag_en)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [15:0] instr;
        logic [15:0] pc2;
        logic        wbwe;
        logic [3:0]  wbrd;
        logic [15:0] wbdata;
        logic [2:0]  flags;
        logic        e_valid;
        logic [15:0] e_rsd;
        logic [15:0] e_rtd;
        logic [15:0] e_imm;
        logic [3:0]  e_rs;
        logic [3:0]  e_rt;
        logic [3:0]  e_rd;
        logic [4:0]  e_ctl;   // {alu_src, reg_write, mem_read, mem_write, halt}
        logic [2:0]  e_fen;
        logic        e_taken;
        logic [15:0] e_tgt;
        logic        chk_tgt;
    } vec_t;

    localparam int NV = 14;
    vec_t vt [NV];

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        ifid_valid = 1'b0;
        wb_we = 1'b0;
        exmem_valid = 1'b0;
        exmem_reg_write = 1'b0;
        tick();
    endtask

    task automatic wb_write(input logic [3:0] r, input logic [15:0] d);
        ifid_valid = 1'b0;
        wb_we = 1'b1; wb_rd = r; wb_data = d;
        tick();
        wb_we = 1'b0;
    endtask

    task automatic drive(input logic [15:0] instr, input logic [15:0] pc2);
        ifid_valid = 1'b1; ifid_instr = instr; ifid_pc2 = pc2;
    endtask

    initial begin
        //         instr    pc2      we   rd    wdata    flg     v    rsd      rtd      imm      rs    rt    rd    ctl       fen     tk   tgt      ct
        vt[0]  = '{16'h0312, 16'h0002, 1'b0, 4'd0, 16'h0000, 3'b000, 1'b1, 16'h0005, 16'h0003, 16'h0000, 4'd1, 4'd2, 4'd3, 5'b01000, 3'b111, 1'b0, 16'h0000, 1'b0};
        vt[1]  = '{16'h2540, 16'h0004, 1'b1, 4'd4, 16'hBEEF, 3'b000, 1'b1, 16'hBEEF, 16'h0000, 16'h0000, 4'd4, 4'd0, 4'd5, 5'b01000, 3'b010, 1'b0, 16'h0000, 1'b0};
        vt[2]  = '{16'h8212, 16'h0006, 1'b0, 4'd0, 16'h0000, 3'b000, 1'b1, 16'h0005, 16'h0000, 16'h0004, 4'd1, 4'd0, 4'd2, 5'b11100, 3'b000, 1'b0, 16'h0000, 1'b0};
        vt[3]  = '{16'h921F, 16'h0008, 1'b0, 4'd0, 16'h0000, 3'b000, 1'b1, 16'h0005, 16'h0003, 16'hFFFE, 4'd1, 4'd2, 4'd2, 5'b10010, 3'b000, 1'b0, 16'h0000, 1'b0};
        vt[4]  = '{16'hA7AB, 16'h000A, 1'b0, 4'd0, 16'h0000, 3'b000, 1'b1, 16'h00F0, 16'h0000, 16'h00AB, 4'd7, 4'd0, 4'd7, 5'b11000, 3'b000, 1'b0, 16'h0000, 1'b0};
        vt[5]  = '{16'h5315, 16'h000C, 1'b0, 4'd0, 16'h0000, 3'b000, 1'b1, 16'h0005, 16'h0000, 16'h0005, 4'd1, 4'd0, 4'd3, 5'b11000, 3'b010, 1'b0, 16'h0000, 1'b0};
        vt[6]  = '{16'hE800, 16'h0040, 1'b0, 4'd0, 16'h0000, 3'b000, 1'b1, 16'h0000, 16'h0000, 16'h0000, 4'd0, 4'd0, 4'd8, 5'b01000, 3'b000, 1'b0, 16'h0000, 1'b0};
        vt[7]  = '{16'h0901, 16'h0042, 1'b1, 4'd0, 16'hFFFF, 3'b000, 1'b1, 16'h0000, 16'h0005, 16'h0000, 4'd0, 4'd1, 4'd9, 5'b01000, 3'b111, 1'b0, 16'h0000, 1'b0};
        vt[8]  = '{16'h3A12, 16'h0044, 1'b0, 4'd0, 16'h0000, 3'b000, 1'b1, 16'h0005, 16'h0003, 16'h0000, 4'd1, 4'd2, 4'd10, 5'b01000, 3'b000, 1'b0, 16'h0000, 1'b0};
        vt[9]  = '{16'hC004, 16'h0100, 1'b0, 4'd0, 16'h0000, 3'b010, 1'b0, 16'h0000, 16'h0000, 16'h0000, 4'd0, 4'd0, 4'd0, 5'b00000, 3'b000, 1'b0, 16'h0108, 1'b1};
        vt[10] = '{16'hC5FE, 16'h0100, 1'b0, 4'd0, 16'h0000, 3'b000, 1'b0, 16'h0000, 16'h0000, 16'h0000, 4'd0, 4'd0, 4'd0, 5'b00000, 3'b000, 1'b1, 16'h00FC, 1'b1};
        vt[11] = '{16'hC600, 16'h0200, 1'b0, 4'd0, 16'h0000, 3'b100, 1'b0, 16'h0000, 16'h0000, 16'h0000, 4'd0, 4'd0, 4'd0, 5'b00000, 3'b000, 1'b1, 16'h0200, 1'b1};
        vt[12] = '{16'hCC00, 16'h0300, 1'b0, 4'd0, 16'h0000, 3'b000, 1'b0, 16'h0000, 16'h0000, 16'h0000, 4'd0, 4'd0, 4'd0, 5'b00000, 3'b000, 1'b0, 16'h0300, 1'b1};
        vt[13] = '{16'hDE10, 16'h0400, 1'b0, 4'd0, 16'h0000, 3'b000, 1'b0, 16'h0000, 16'h0000, 16'h0000, 4'd0, 4'd0, 4'd0, 5'b00000, 3'b000, 1'b1, 16'h0005, 1'b1};

        rst = 1'b1;
        ifid_valid = 1'b0; ifid_instr = 16'h0000; ifid_pc2 = 16'h0000;
        wb_we = 1'b0; wb_rd = 4'd0; wb_data = 16'h0000; ex_flags = 3'b000;
        exmem_valid = 1'b0; exmem_reg_write = 1'b0; exmem_rd = 4'd0;
        #3;
        chk("rst.idex_valid", 16'(idex_valid), 16'h0);
        chk("rst.halted", 16'(halted), 16'h0);
        chk("rst.stall", 16'(stall), 16'h0);
        chk("rst.branch_taken", 16'(branch_taken), 16'h0);
        chk("rst.idex_ctl", 16'({idex_alu_src, idex_reg_write, idex_mem_read, idex_mem_write, idex_halt}), 16'h0);
        chk("rst.idex_flag_en", 16'(idex_flag_en), 16'h0);
        tick(); tick();
        rst = 1'b0;
        tick();

        wb_write(4'd1, 16'h0005);
        wb_write(4'd2, 16'h0003);
        wb_write(4'd4, 16'h1234);
        wb_write(4'd7, 16'h00F0);

        for (int i = 0; i < NV; i++) begin
            drive(vt[i].instr, vt[i].pc2);
            wb_we = vt[i].wbwe; wb_rd = vt[i].wbrd; wb_data = vt[i].wbdata;
            ex_flags = vt[i].flags;
            @(negedge clk);
            chk($sformatf("v%0d.stall", i), 16'(stall), 16'h0);
            chk($sformatf("v%0d.branch_taken", i), 16'(branch_taken), 16'(vt[i].e_taken));
            if (vt[i].chk_tgt)
                chk($sformatf("v%0d.branch_target", i), branch_target, vt[i].e_tgt);
            tick();
            chk($sformatf("v%0d.idex_valid", i), 16'(idex_valid), 16'(vt[i].e_valid));
            if (vt[i].e_valid) begin
                chk($sformatf("v%0d.opcode", i), 16'(idex_opcode), 16'(vt[i].instr[15:12]));
                chk($sformatf("v%0d.pc2", i), idex_pc2, vt[i].pc2);
                chk($sformatf("v%0d.rs_data", i), idex_rs_data, vt[i].e_rsd);
                chk($sformatf("v%0d.rt_data", i), idex_rt_data, vt[i].e_rtd);
                chk($sformatf("v%0d.imm", i), idex_imm, vt[i].e_imm);
                chk($sformatf("v%0d.rs", i), 16'(idex_rs), 16'(vt[i].e_rs));
                chk($sformatf("v%0d.rt", i), 16'(idex_rt), 16'(vt[i].e_rt));
                chk($sformatf("v%0d.rd", i), 16'(idex_rd), 16'(vt[i].e_rd));
                chk($sformatf("v%0d.flag_en", i), 16'(idex_flag_en), 16'(vt[i].e_fen));
            end
            chk($sformatf("v%0d.ctl", i),
                16'({idex_alu_src, idex_reg_write, idex_mem_read, idex_mem_write, idex_halt}),
                16'(vt[i].e_ctl));
            idle();
        end
        ex_flags = 3'b000;

        // Load-use: LW R2,R1,2 then ADD R3,R2,R2
        drive(16'h8212, 16'h0010);
        @(negedge clk); chk("lu.lw_stall", 16'(stall), 16'h0);
        tick();
        chk("lu.lw_valid", 16'(idex_valid), 16'h1);
        chk("lu.lw_imm", idex_imm, 16'h0004);
        drive(16'h0322, 16'h0012);
        @(negedge clk); chk("lu.stall1", 16'(stall), 16'h1);
        tick();
        chk("lu.bubble", 16'(idex_valid), 16'h0);
        chk("lu.bubble_rw", 16'(idex_reg_write), 16'h0);
        @(negedge clk); chk("lu.stall2", 16'(stall), 16'h0);
        tick();
        chk("lu.add_valid", 16'(idex_valid), 16'h1);
        chk("lu.add_rs", 16'(idex_rs), 16'h2);
        chk("lu.add_rd", 16'(idex_rd), 16'h3);
        idle();

        // Flag hazard: SUB then B EQ,+4 at pc2 0x0010; Z already 1 but stall must mask it
        drive(16'h1312, 16'h000E);
        tick();
        chk("fh.sub_fen", 16'(idex_flag_en), 16'h7);
        drive(16'hC204, 16'h0010);
        ex_flags = 3'b010;
        @(negedge clk);
        chk("fh.stall", 16'(stall), 16'h1);
        chk("fh.masked_taken", 16'(branch_taken), 16'h0);
        tick();
        chk("fh.bubble", 16'(idex_valid), 16'h0);
        @(negedge clk);
        chk("fh.stall2", 16'(stall), 16'h0);
        chk("fh.taken", 16'(branch_taken), 16'h1);
        chk("fh.target", branch_target, 16'h0018);
        tick();
        chk("fh.b_not_valid", 16'(idex_valid), 16'h0);
        idle();
        ex_flags = 3'b000;

        // BR register hazard: LLB R6,0x40 then BR 111,R6
        drive(16'hB640, 16'h0020);
        tick();
        chk("br.llb_imm", idex_imm, 16'h0040);
        chk("br.llb_rw", 16'(idex_reg_write), 16'h1);
        drive(16'hDE60, 16'h0022);
        @(negedge clk); chk("br.stall_idex", 16'(stall), 16'h1);
        tick();
        exmem_valid = 1'b1; exmem_reg_write = 1'b1; exmem_rd = 4'd6;
        @(negedge clk);
        chk("br.stall_exmem", 16'(stall), 16'h1);
        chk("br.masked_taken", 16'(branch_taken), 16'h0);
        tick();
        exmem_valid = 1'b0; exmem_reg_write = 1'b0;
        wb_we = 1'b1; wb_rd = 4'd6; wb_data = 16'h0040;
        @(negedge clk);
        chk("br.stall_done", 16'(stall), 16'h0);
        chk("br.taken", 16'(branch_taken), 16'h1);
        chk("br.target", branch_target, 16'h0040);
        tick();
        chk("br.not_valid", 16'(idex_valid), 16'h0);
        idle();

        // Halt, then reset while the next instruction is stalled
        drive(16'hF000, 16'h0030);
        @(negedge clk); chk("hlt.stall0", 16'(stall), 16'h0);
        tick();
        chk("hlt.idex_halt", 16'(idex_halt), 16'h1);
        chk("hlt.valid", 16'(idex_valid), 16'h1);
        chk("hlt.halted", 16'(halted), 16'h1);
        drive(16'h0312, 16'h0032);
        @(negedge clk); chk("hlt.stall", 16'(stall), 16'h1);
        tick();
        chk("hlt.bubble", 16'(idex_valid), 16'h0);
        chk("hlt.sticky", 16'(halted), 16'h1);
        drive(16'hCE00, 16'h0034);
        @(negedge clk);
        chk("hlt.no_branch", 16'(branch_taken), 16'h0);
        chk("hlt.stall_b", 16'(stall), 16'h1);
        drive(16'h0312, 16'h0032);
        #2 rst = 1'b1;
        #1;
        chk("rst2.halted", 16'(halted), 16'h0);
        chk("rst2.idex_halt", 16'(idex_halt), 16'h0);
        chk("rst2.stall", 16'(stall), 16'h0);
        tick();
        rst = 1'b0;
        @(negedge clk);
        chk("rst2.valid_in_rst", 16'(idex_valid), 16'h0);
        tick();
        chk("rst2.add_valid", 16'(idex_valid), 16'h1);
        chk("rst2.rf_cleared", idex_rs_data, 16'h0000);
        idle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
